// File: rtl/spi_controller_tx_pkg.sv
// -----------------------------------------------------------------------------
// spi_ctrl_pkg
// Shared types and frame layout for the SPI register-interface controller.
// Frame on the wire, MSB first: {rw, addr[6:0], data[7:0]}.
// No ports (package).
// -----------------------------------------------------------------------------
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_e;

    localparam int FRAME_W  = 16;
    localparam int RW_BIT   = 15;
    localparam int ADDR_LSB = 8;
    localparam int DATA_LSB = 0;

endpackage

// File: rtl/spi_controller_tx_if.sv
// -----------------------------------------------------------------------------
// spi_controller_tx_if
// Host-side request/response bundle for spi_controller_tx.
//   req_valid/req_ready  one request per handshake
//   req_rw/addr/data     register request (1 = write)
//   rsp_valid/rsp_data   one-cycle completion pulse and read data
//   busy                 controller owns the bus
// Modports: master = host issuing requests, slave = controller.
// -----------------------------------------------------------------------------
interface spi_controller_tx_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              busy;

    modport master (
        output req_valid, req_rw, req_addr, req_data,
        input  req_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_data,
        output req_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/spi_controller_tx_clk_tick.sv
// -----------------------------------------------------------------------------
// spi_clk_tick
// Divide-by-CLK_DIV phase timer. tick_o is high for one clk in every CLK_DIV
// cycles; clear_i restarts the count so every FSM state begins a full phase.
// Ports: clk, rst_n (async, active low), clear_i, tick_o.
// -----------------------------------------------------------------------------
module spi_clk_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    output logic tick_o
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/spi_controller_tx.sv
// -----------------------------------------------------------------------------
// spi_controller_tx
// SPI mode-0 initiator for the peripheral register interface. One request per
// handshake is serialised as {rw, addr, data}, MSB first, under active-low ncs.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   bus (slave modport)  req_valid/ready/rw/addr/data, rsp_valid/data, busy
//   ncs, sclk, copi      SPI outputs (sclk idles low)
//   cipo                 SPI input
// Build option SPI_READ_EN: when defined, read frames are honoured and cipo is
// captured during the data bits; otherwise every frame is a write and rsp_data
// is tied to zero.
//
// state | meaning
// IDLE  | ready for a request, ncs high
// SETUP | ncs low, first bit on copi, one half period before first rise
// SHIFT | 16 bit periods, low half then high half
// HOLD  | sclk low, ncs held low for one half period after last fall
// GAP   | ncs high deselect time; rsp_valid on its last cycle
// -----------------------------------------------------------------------------
module spi_controller_tx
    import spi_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int ADDR_W  = RW_BIT - ADDR_LSB,
    parameter int DATA_W  = ADDR_LSB - DATA_LSB
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_controller_tx_if.slave bus,
    output logic               ncs,
    output logic               sclk,
    output logic               copi,
    input  logic               cipo
);
    localparam int F_W   = 1 + ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(F_W);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(F_W - 1);
    // bit_cnt value of the first data bit (frame bit DATA_W-1)
    localparam logic [CNT_W-1:0] DATA_FIRST = CNT_W'(1 + ADDR_W);

    state_e           state_q;
    state_e           state_d;
    logic [F_W-1:0]   shift_q;
    logic [F_W-1:0]   frame_in;
    logic [CNT_W-1:0] bit_cnt_q;
    logic             sclk_q;
    logic             gap_last_q;
    logic             tick;
    logic             accept;
    logic             rsp_valid;

    spi_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (state_d != state_q),
        .tick_o  (tick)
    );

    assign accept = bus.req_valid && bus.req_ready;

    always_comb begin
        state_d       = state_q;
        bus.req_ready = 1'b0;
        ncs           = 1'b1;
        rsp_valid     = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_d = SETUP;
            end
            SETUP: begin
                ncs = 1'b0;
                if (tick) state_d = SHIFT;
            end
            SHIFT: begin
                ncs = 1'b0;
                // leave on the falling edge that ends the last bit
                if (tick && sclk_q && (bit_cnt_q == BIT_LAST)) state_d = HOLD;
            end
            HOLD: begin
                ncs = 1'b0;
                if (tick) state_d = GAP;
            end
            GAP: begin
                if (gap_last_q) begin
                    rsp_valid = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            sclk_q     <= 1'b0;
            gap_last_q <= 1'b0;
        end else begin
            if (accept) begin
                shift_q <= frame_in;
            end
            if ((state_q == SHIFT) && tick) begin
                sclk_q <= ~sclk_q;
                if (sclk_q) begin
                    shift_q   <= {shift_q[F_W-2:0], 1'b0};
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                end
            end
            // full deselect half period elapsed; one more cycle carries rsp_valid
            gap_last_q <= (state_q == GAP) && tick;
        end
    end

    assign sclk           = sclk_q;
    assign copi           = ~ncs & shift_q[F_W-1];
    assign bus.busy       = ~bus.req_ready;
    assign bus.rsp_valid  = rsp_valid;

`ifdef SPI_READ_EN
    logic              rw_q;
    logic [DATA_W-1:0] rx_q;
    logic [DATA_W-1:0] rsp_data_q;

    assign frame_in = {bus.req_rw, bus.req_addr, bus.req_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q       <= 1'b0;
            rx_q       <= '0;
            rsp_data_q <= '0;
        end else begin
            if (accept) begin
                rw_q <= bus.req_rw;
            end
            // sample on the rising sclk of each data bit of a read
            if ((state_q == SHIFT) && tick && !sclk_q && !rw_q && (bit_cnt_q >= DATA_FIRST)) begin
                rx_q <= {rx_q[DATA_W-2:0], cipo};
            end
            if (rsp_valid && !rw_q) begin
                rsp_data_q <= rx_q;
            end
        end
    end

    assign bus.rsp_data = rsp_data_q;
`else
    logic unused_inputs;

    assign frame_in      = {1'b1, bus.req_addr, bus.req_data};
    assign bus.rsp_data  = '0;
    assign unused_inputs = ^{cipo, bus.req_rw};
`endif
endmodule

// File: tb/tb_spi_controller_tx.sv
// -----------------------------------------------------------------------------
// tb_spi_controller_tx
// Directed bench for spi_controller_tx. A small SPI peripheral model records
// frames on rising sclk, keeps a register array updated by write frames, and
// drives a programmed byte on cipo during the data bits.
// -----------------------------------------------------------------------------
module tb_spi_controller_tx;
    import spi_ctrl_pkg::*;

    localparam int CLK_DIV = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic ncs;
    logic sclk;
    logic copi;
    logic cipo;

    spi_controller_tx_if bus ();

    spi_controller_tx #(.CLK_DIV(CLK_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .ncs   (ncs),
        .sclk  (sclk),
        .copi  (copi),
        .cipo  (cipo)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // peripheral model
    logic [FRAME_W-1:0] mon_frame = '0;
    int                 mon_rises = 0;
    int                 last_rises = 0;
    logic [FRAME_W-1:0] last_frame = '0;
    logic [FRAME_W-1:0] frame_log[$];
    logic [7:0]         regs [0:127];
    logic [7:0]         resp_byte = 8'h00;
    int                 rsp_cnt = 0;
    int                 n_acc = 0;

    always @(negedge ncs) begin
        mon_frame = '0;
        mon_rises = 0;
    end

    always @(posedge sclk) begin
        if (ncs === 1'b0) begin
            mon_frame = {mon_frame[FRAME_W-2:0], copi};
            mon_rises = mon_rises + 1;
        end
    end

    always @(posedge ncs) begin
        last_rises = mon_rises;
        if (mon_rises == FRAME_W) begin
            last_frame = mon_frame;
            frame_log.push_back(mon_frame);
            if (mon_frame[RW_BIT] === 1'b1) regs[mon_frame[14:8]] = mon_frame[7:0];
        end
    end

    always_comb begin
        cipo = 1'b0;
        if (ncs === 1'b0 && mon_rises >= 8 && mon_rises < 16) cipo = resp_byte[3'(15 - mon_rises)];
    end

    always @(posedge clk) begin
        if (bus.rsp_valid === 1'b1) rsp_cnt = rsp_cnt + 1;
        if (bus.req_valid === 1'b1 && bus.req_ready === 1'b1) n_acc = n_acc + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic run_frame(input logic rw, input logic [6:0] addr, input logic [7:0] data,
                             output int lat_rsp, output int lat_rdy);
        int k;
        lat_rsp = -1;
        lat_rdy = -1;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_rw    = rw;
        bus.req_addr  = addr;
        bus.req_data  = data;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (k = 0; k < 400 && lat_rdy < 0; k++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1 && lat_rsp < 0) lat_rsp = k;
            if (bus.req_ready === 1'b1) lat_rdy = k;
            else @(posedge clk);
        end
    endtask

    task automatic wait_ready(input string name);
        int k;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) break;
        end
        n_checks++;
        if (k == 400) begin
            n_fail++;
            $display("FAIL %s_timeout: got ready=%b, expected ready=1 within 400 cycles", name, bus.req_ready);
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0;
        bus.req_rw    = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (ncs !== 1'b1) begin n_fail++; $display("FAIL reset_ncs: got %b expected 1", ncs); end
        n_checks++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
        n_checks++; if (copi !== 1'b0) begin n_fail++; $display("FAIL reset_copi: got %b expected 0", copi); end
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.req_ready); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
        n_checks++; if (bus.rsp_data !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_data: got %h expected 00", bus.rsp_data); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b expected 1", bus.req_ready); end
    endtask

    task automatic test_write();
        int lr, ly, r0;
        r0 = rsp_cnt;
        resp_byte = 8'h00;
        run_frame(1'b1, 7'h00, 8'hFF, lr, ly);
        n_checks++; if (lr != 140) begin n_fail++; $display("FAIL write_rsp_latency: got %0d expected 140", lr); end
        n_checks++; if (ly != 141) begin n_fail++; $display("FAIL write_ready_latency: got %0d expected 141", ly); end
        n_checks++; if (last_frame !== 16'h80FF) begin n_fail++; $display("FAIL write_frame: got %h expected 80ff", last_frame); end
        n_checks++; if (last_rises != 16) begin n_fail++; $display("FAIL write_sclk_rises: got %0d expected 16", last_rises); end
        n_checks++; if (regs[0] !== 8'hFF) begin n_fail++; $display("FAIL write_reg0: got %h expected ff", regs[0]); end
        n_checks++; if (rsp_cnt - r0 != 1) begin n_fail++; $display("FAIL write_rsp_pulses: got %0d expected 1", rsp_cnt - r0); end
        n_checks++; if (bus.rsp_data !== 8'h00) begin n_fail++; $display("FAIL write_rsp_data: got %h expected 00", bus.rsp_data); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_end: got %b expected 0", bus.busy); end
    endtask

`ifdef SPI_READ_EN
    task automatic test_read();
        int lr, ly;
        resp_byte = 8'hA5;
        run_frame(1'b0, 7'h04, 8'h00, lr, ly);
        n_checks++; if (last_frame !== 16'h0400) begin n_fail++; $display("FAIL read_frame: got %h expected 0400", last_frame); end
        n_checks++; if (last_rises != 16) begin n_fail++; $display("FAIL read_sclk_rises: got %0d expected 16", last_rises); end
        n_checks++; if (lr != 140) begin n_fail++; $display("FAIL read_rsp_latency: got %0d expected 140", lr); end
        n_checks++; if (bus.rsp_data !== 8'hA5) begin n_fail++; $display("FAIL read_rsp_data: got %h expected a5", bus.rsp_data); end
    endtask
`else
    task automatic test_write_only();
        int lr, ly;
        resp_byte = 8'hA5;
        run_frame(1'b0, 7'h05, 8'h3C, lr, ly);
        n_checks++; if (last_frame !== 16'h853C) begin n_fail++; $display("FAIL wo_frame: got %h expected 853c", last_frame); end
        n_checks++; if (regs[5] !== 8'h3C) begin n_fail++; $display("FAIL wo_reg5: got %h expected 3c", regs[5]); end
        n_checks++; if (bus.rsp_data !== 8'h00) begin n_fail++; $display("FAIL wo_rsp_data: got %h expected 00", bus.rsp_data); end
        n_checks++; if (ly != 141) begin n_fail++; $display("FAIL wo_ready_latency: got %0d expected 141", ly); end
    endtask
`endif

    task automatic test_hold_valid();
        int k, acc0, log0;
        acc0 = n_acc;
        log0 = frame_log.size();
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_rw    = 1'b1;
        bus.req_addr  = 7'h10;
        bus.req_data  = 8'h11;
        @(posedge clk);
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) break;
            bus.req_addr = 7'h20;
            bus.req_data = 8'(k);
        end
        n_checks++;
        if (k == 400) begin n_fail++; $display("FAIL hold_first_timeout: got ready=%b expected 1", bus.req_ready); end
        bus.req_data = 8'h33;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        wait_ready("hold_second");
        n_checks++; if (n_acc - acc0 != 2) begin n_fail++; $display("FAIL hold_accepts: got %0d expected 2", n_acc - acc0); end
        n_checks++; if (frame_log.size() - log0 != 2) begin n_fail++; $display("FAIL hold_frames: got %0d expected 2", frame_log.size() - log0); end
        n_checks++; if (frame_log[log0] !== 16'h9011) begin n_fail++; $display("FAIL hold_frame1: got %h expected 9011", frame_log[log0]); end
        n_checks++; if (frame_log[log0+1] !== 16'hA033) begin n_fail++; $display("FAIL hold_frame2: got %h expected a033", frame_log[log0+1]); end
        n_checks++; if (regs[7'h20] !== 8'h33) begin n_fail++; $display("FAIL hold_reg20: got %h expected 33", regs[7'h20]); end
    endtask

    task automatic test_back_to_back(input logic [7:0] exp_rsp);
        int k, gap, log0;
        log0 = frame_log.size();
        gap  = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_rw    = 1'b1;
        bus.req_addr  = 7'h01;
        bus.req_data  = 8'h0F;
        @(posedge clk);
        #1;
        bus.req_addr = 7'h02;
        bus.req_data = 8'hF0;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (ncs === 1'b1) gap++;
            if (bus.rsp_valid === 1'b1 && bus.req_ready === 1'b1) begin
                n_checks++; n_fail++;
                $display("FAIL b2b_ready_with_rsp: got ready=1 expected 0 during rsp_valid");
            end
            if (bus.req_ready === 1'b1) break;
        end
        n_checks++;
        if (k == 400) begin n_fail++; $display("FAIL b2b_first_timeout: got ready=%b expected 1", bus.req_ready); end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (ncs !== 1'b0) begin n_fail++; $display("FAIL b2b_second_start: got ncs=%b expected 0", ncs); end
        wait_ready("b2b_second");
        n_checks++; if (gap < CLK_DIV) begin n_fail++; $display("FAIL b2b_deselect: got %0d cycles expected >= %0d", gap, CLK_DIV); end
        n_checks++; if (frame_log[log0] !== 16'h810F) begin n_fail++; $display("FAIL b2b_frame1: got %h expected 810f", frame_log[log0]); end
        n_checks++; if (frame_log[log0+1] !== 16'h82F0) begin n_fail++; $display("FAIL b2b_frame2: got %h expected 82f0", frame_log[log0+1]); end
        n_checks++; if (regs[1] !== 8'h0F) begin n_fail++; $display("FAIL b2b_reg1: got %h expected 0f", regs[1]); end
        n_checks++; if (regs[2] !== 8'hF0) begin n_fail++; $display("FAIL b2b_reg2: got %h expected f0", regs[2]); end
        n_checks++; if (bus.rsp_data !== exp_rsp) begin n_fail++; $display("FAIL b2b_rsp_data_held: got %h expected %h", bus.rsp_data, exp_rsp); end
    endtask

    task automatic test_reset_mid_frame();
        int r0, log0;
        r0   = rsp_cnt;
        log0 = frame_log.size();
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_rw    = 1'b1;
        bus.req_addr  = 7'h7F;
        bus.req_data  = 8'hFF;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        n_checks++; if ({ncs, sclk, copi} !== 3'b011) begin n_fail++; $display("FAIL abort_pre: got ncs,sclk,copi=%b expected 011", {ncs, sclk, copi}); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (ncs !== 1'b1) begin n_fail++; $display("FAIL abort_ncs: got %b expected 1", ncs); end
        n_checks++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL abort_sclk: got %b expected 0", sclk); end
        n_checks++; if (copi !== 1'b0) begin n_fail++; $display("FAIL abort_copi: got %b expected 0", copi); end
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b expected 1", bus.req_ready); end
        n_checks++; if (bus.rsp_data !== 8'h00) begin n_fail++; $display("FAIL abort_rsp_data: got %h expected 00", bus.rsp_data); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(posedge clk);
        @(negedge clk);
        n_checks++; if (rsp_cnt != r0) begin n_fail++; $display("FAIL abort_no_rsp: got %0d pulses expected 0", rsp_cnt - r0); end
        n_checks++; if (frame_log.size() != log0) begin n_fail++; $display("FAIL abort_no_frame: got %0d frames expected 0", frame_log.size() - log0); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) regs[i] = 8'h00;
        test_reset();
        test_write();
`ifdef SPI_READ_EN
        test_read();
        test_hold_valid();
        test_back_to_back(8'hA5);
`else
        test_write_only();
        test_hold_valid();
        test_back_to_back(8'h00);
`endif
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
